// File: rtl/imu_frame_assembler.sv
// -----------------------------------------------------------------------------
// imu_frame_assembler
//   Collects six per-axis raw IMU words (a_x, a_y, a_z, w_x, w_y, w_z), which
//   may arrive in any order. Each complete set is handed to the madgwick filter
//   through a valid/ready output. The block is double-buffered: an assembly
//   register fills while the previous frame waits in the output slot.
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready.
//   Valid never depends on ready. The payload (s_axis/s_data, frame outputs)
//   must be stable while valid is high and ready is low.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   s_valid/s_ready      axis word handshake
//   s_axis, s_data       axis index (0..5 legal) and signed sample
//   m_valid/m_ready      frame handshake toward the filter
//   a_x..w_z             frame outputs, stable while m_valid=1
//   frame_cnt            frames delivered, wraps
//   err_dup, err_axis    sticky error flags; err_clr clears both
//   bias_we/sel/data     bias register write port (IMU_BIAS_CORR_EN only)
//
// Optional build macro: IMU_BIAS_CORR_EN. When defined, each legal word is
//   stored as sat(s_data - bias[axis]), saturated to its axis width.
// -----------------------------------------------------------------------------
module imu_frame_assembler #(
   parameter int ACC_W  = 16,
   parameter int GYRO_W = 16,
   parameter int CNT_W  = 16,
   localparam int DW    = (ACC_W > GYRO_W) ? ACC_W : GYRO_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [2:0]        s_axis,
   input  logic [DW-1:0]     s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ACC_W-1:0]  a_x,
   output logic [ACC_W-1:0]  a_y,
   output logic [ACC_W-1:0]  a_z,
   output logic [GYRO_W-1:0] w_x,
   output logic [GYRO_W-1:0] w_y,
   output logic [GYRO_W-1:0] w_z,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              err_dup,
   output logic              err_axis,
`ifdef IMU_BIAS_CORR_EN
   input  logic              bias_we,
   input  logic [2:0]        bias_sel,
   input  logic [DW-1:0]     bias_data,
`endif
   input  logic              err_clr
);

   // Output slot FSM: the slot state is exactly m_valid.
   typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

   slot_state_e           slot_q, slot_d;
   logic [5:0]            mask_q, mask_d;
   logic [DW-1:0]         asm_q [6];
   logic [DW-1:0]         asm_d [6];
   logic [DW-1:0]         out_q [6];
   logic [DW-1:0]         out_d [6];
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_dup_q, err_dup_d;
   logic                  err_axis_q, err_axis_d;

   logic                  asm_ready;
   logic                  transfer;
   logic                  drain;
   logic                  accept;
   logic                  axis_legal;
   logic                  dup;
   logic [DW-1:0]         acc_word;
   logic [DW-1:0]         gyro_word;

`ifdef IMU_BIAS_CORR_EN
   localparam logic signed [DW:0] ACC_MAX  = $signed({{(DW-ACC_W+2){1'b0}}, {(ACC_W-1){1'b1}}});
   localparam logic signed [DW:0] ACC_MIN  = ~ACC_MAX;
   localparam logic signed [DW:0] GYRO_MAX = $signed({{(DW-GYRO_W+2){1'b0}}, {(GYRO_W-1){1'b1}}});
   localparam logic signed [DW:0] GYRO_MIN = ~GYRO_MAX;

   logic [DW-1:0]         bias_q [6];
   logic [DW-1:0]         bias_cur;
   logic signed [DW:0]    acc_diff, gyro_diff;
   logic signed [DW:0]    acc_sat, gyro_sat;
`endif

   assign asm_ready  = (mask_q == 6'h3F);
   assign drain      = (slot_q == SLOT_FULL) && m_ready;
   // The slot can take a new frame if it is empty or being drained this cycle.
   assign transfer   = asm_ready && ((slot_q == SLOT_EMPTY) || m_ready);
   assign s_ready    = !(asm_ready && (slot_q == SLOT_FULL) && !m_ready);
   assign accept     = s_valid && s_ready;
   assign axis_legal = (s_axis < 3'd6);

   // Word value to store, per axis class.
`ifdef IMU_BIAS_CORR_EN
   always_comb begin
      bias_cur = '0;
      for (int i = 0; i < 6; i++) begin
         if (s_axis == 3'(i)) bias_cur = bias_q[i];
      end
      acc_diff  = $signed({{(DW+1-ACC_W){s_data[ACC_W-1]}}, s_data[ACC_W-1:0]})
                - $signed({{(DW+1-ACC_W){bias_cur[ACC_W-1]}}, bias_cur[ACC_W-1:0]});
      gyro_diff = $signed({{(DW+1-GYRO_W){s_data[GYRO_W-1]}}, s_data[GYRO_W-1:0]})
                - $signed({{(DW+1-GYRO_W){bias_cur[GYRO_W-1]}}, bias_cur[GYRO_W-1:0]});
      acc_sat   = (acc_diff > ACC_MAX) ? ACC_MAX : (acc_diff < ACC_MIN) ? ACC_MIN : acc_diff;
      gyro_sat  = (gyro_diff > GYRO_MAX) ? GYRO_MAX : (gyro_diff < GYRO_MIN) ? GYRO_MIN : gyro_diff;
      acc_word  = acc_sat[DW-1:0];
      gyro_word = gyro_sat[DW-1:0];
   end
`else
   assign acc_word  = s_data;
   assign gyro_word = s_data;
`endif

   // Slot FSM next state.
   always_comb begin
      slot_d = slot_q;
      if (transfer)   slot_d = SLOT_FULL;
      else if (drain) slot_d = SLOT_EMPTY;
   end

   // Assembly, output slot, counter and error flags.
   always_comb begin
      // A transfer empties the mask first, so a word accepted in the same
      // cycle starts the next frame.
      mask_d = transfer ? 6'h00 : mask_q;
      asm_d  = asm_q;
      out_d  = out_q;
      dup    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (accept && axis_legal && (s_axis == 3'(i))) begin
            if (mask_d[i]) dup = 1'b1;
            mask_d[i] = 1'b1;
            asm_d[i]  = (i < 3) ? acc_word : gyro_word;
         end
      end
      if (transfer) out_d = asm_q;
      cnt_d      = drain ? cnt_q + 1'b1 : cnt_q;
      // A new error in the same cycle as err_clr keeps the flag set.
      err_dup_d  = (err_clr ? 1'b0 : err_dup_q) | dup;
      err_axis_d = (err_clr ? 1'b0 : err_axis_q) | (accept && !axis_legal);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q     <= SLOT_EMPTY;
         mask_q     <= '0;
         cnt_q      <= '0;
         err_dup_q  <= 1'b0;
         err_axis_q <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            asm_q[i] <= '0;
            out_q[i] <= '0;
         end
      end else begin
         slot_q     <= slot_d;
         mask_q     <= mask_d;
         cnt_q      <= cnt_d;
         err_dup_q  <= err_dup_d;
         err_axis_q <= err_axis_d;
         asm_q      <= asm_d;
         out_q      <= out_d;
      end
   end

`ifdef IMU_BIAS_CORR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 6; i++) bias_q[i] <= '0;
      end else if (bias_we) begin
         for (int i = 0; i < 6; i++) begin
            if (bias_sel == 3'(i)) bias_q[i] <= bias_data;
         end
      end
   end
`endif

   assign m_valid   = (slot_q == SLOT_FULL);
   assign a_x       = out_q[0][ACC_W-1:0];
   assign a_y       = out_q[1][ACC_W-1:0];
   assign a_z       = out_q[2][ACC_W-1:0];
   assign w_x       = out_q[3][GYRO_W-1:0];
   assign w_y       = out_q[4][GYRO_W-1:0];
   assign w_z       = out_q[5][GYRO_W-1:0];
   assign frame_cnt = cnt_q;
   assign err_dup   = err_dup_q;
   assign err_axis  = err_axis_q;

endmodule

// File: doc/imu_frame_assembler.md
Name: imu_frame_assembler

Overview:
- Upstream stage of the madgwick filter.
- Collects per-axis raw IMU words (a_x, a_y, a_z, w_x, w_y, w_z) arriving one at a time from the sensor reader. Words may arrive in any order.
- Assembles each set into a complete six-axis frame and presents it to the madgwick valid_in/ready_in interface.
- Double-buffered: one frame can be assembling while the previous frame waits for the filter.

Parameters:
- ACC_W, 16, accelerometer word width (matches `ACC_WIDTH`).
- GYRO_W, 16, gyro word width (matches `GYRO_WIDTH`).
- CNT_W, 16, width of the delivered-frame counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- s_valid  in  1  axis word valid.
- s_ready  out  1  block can accept an axis word.
- s_axis  in  3  axis index: 0=a_x, 1=a_y, 2=a_z, 3=w_x, 4=w_y, 5=w_z; 6 and 7 are illegal.
- s_data  in  max(ACC_W,GYRO_W)  signed sample; the low ACC_W or GYRO_W bits are used according to axis.
- m_valid  out  1  frame valid; drives madgwick valid_in.
- m_ready  in  1  from madgwick ready_in.
- a_x, a_y, a_z  out  ACC_W each  signed frame accelerometer outputs.
- w_x, w_y, w_z  out  GYRO_W each  signed frame gyro outputs.
- frame_cnt  out  CNT_W  frames delivered; wraps.
- err_dup  out  1  sticky: axis written twice within one frame.
- err_axis  out  1  sticky: illegal axis index received.
- err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (asynchronous, rst=1), all cleared: assembly register, 6-bit fill mask, output slot, m_valid=0, all frame outputs=0, frame_cnt=0, err_dup=0, err_axis=0.
- s_ready=1 immediately after reset.
- Reset mid-frame discards any partial or pending frame.
- Word acceptance: s_valid && s_ready at a rising edge of clk.
- Legal axis word:
  - Written to assembly slot[s_axis]; mask bit set.
  - If that mask bit was already set: value overwritten (last write wins), err_dup set.
- Illegal axis word (6 or 7): data dropped, err_axis set. Still consumes a handshake, so s_ready is honoured.
- Assembler states:
  - FILL: mask != 6'h3F.
  - READY: mask == 6'h3F, frame not yet transferred.
- Output slot states: EMPTY (m_valid=0) and FULL (m_valid=1). Outputs hold stable while FULL.
- Transfer: when the assembler is in READY and the output slot is EMPTY or being drained this cycle (m_valid && m_ready):
  - Frame copies to the output registers on the next edge.
  - Mask clears to 0; assembler returns to FILL.
  - m_valid=1.
- Latency: the 6th distinct axis word accepted at edge N gives m_valid=1 after edge N+1. Zero-bubble back-to-back operation when m_ready is held high.
- s_ready = !(assembler READY && output FULL && !m_ready). Upstream stalls only when both buffers are occupied.
- Drain: m_valid && m_ready with no transfer pending → m_valid=0 next cycle. frame_cnt increments by 1 on every m_valid && m_ready and wraps at 2^CNT_W.
- Simultaneous events:
  - Drain and transfer in the same cycle: m_valid stays 1 and the new frame loads.
  - err_clr and a new error in the same cycle: the error wins and the flag stays 1.
- A word accepted in the same cycle the assembler transfers out belongs to the next frame.

Optional Feature:
- Macro: IMU_BIAS_CORR_EN.
- Defined:
  - Adds ports bias_we (in, 1), bias_sel (in, 3), bias_data (in, max width, signed).
  - Six bias registers, reset to 0; written on bias_we. Writes with illegal bias_sel are ignored.
  - Each legal axis word is stored as sat(s_data − bias[axis]), saturated to the signed range of that axis width.
  - No added latency.
- Not defined: ports absent; words stored unmodified.

Test Plan:
- Basic frame: words axis 0..5 = 100, −200, 16384, 5, −5, 0 with m_ready=1 → m_valid one cycle after the 6th word with exactly those values; frame_cnt=1.
- Out-of-order and duplicate: axis order 5,3,1,1(=7),0,2,4 → frame a_y=7; err_dup=1; err_clr pulse → err_dup=0.
- Backpressure: m_ready=0, send 12 words → first frame held stable; s_ready=0 after the 12th word. Raise m_ready → two frames delivered in consecutive cycles; frame_cnt=2.
- Illegal axis: axis 7 word mid-frame → err_axis=1; frame still completes from the six legal words; value unaffected.
- Reset mid-operation: assert rst after 3 words and with an output frame pending → m_valid=0, outputs 0, frame_cnt=0. The next 6 words produce a clean frame.
- IMU_BIAS_CORR_EN:
  - bias[a_x]=100, s_data=−32700 → a_x=−32768 (saturated).
  - bias[w_z]=−10, s_data=32765 → w_z=32767 (saturated).
